// File: rtl/ingress_stager.sv
// ingress_stager: per-lane 2-entry skid buffer converting a valid/ready stream
// into FIFO push/data that respects the FIFO full flag, plus a lane-0 magic
// packet tagger that raises start alongside the Nth push after arming.
module ingress_stager #(
  parameter int WIDTH    = 8,
  parameter int NUM_REQS = 1,
  parameter int IDXWID   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQS-1:0]       in_vld,
  output logic [NUM_REQS-1:0]       in_rdy,
  input  logic [NUM_REQS*WIDTH-1:0] flat_in_data,
  input  logic [NUM_REQS-1:0]       full,
  output logic [NUM_REQS-1:0]       push,
  output logic [NUM_REQS*WIDTH-1:0] flat_data_out,
  input  logic                      arm,
  input  logic [IDXWID-1:0]         magic_idx,
  output logic                      start,
  output logic                      armed,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXWID-1:0] idx_q;
  logic [IDXWID-1:0] cnt_q;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    logic [1:0]       occ_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] din;
    logic             acc;
    logic             psh;

    assign din    = flat_in_data[i*WIDTH +: WIDTH];
    // in_rdy depends only on registered occupancy, never on full or in_vld
    assign in_rdy[i] = (occ_q != 2'd2);
    assign acc       = in_vld[i] & in_rdy[i];
    assign psh       = (occ_q != 2'd0) & ~full[i];
    assign push[i]   = psh;
    assign flat_data_out[i*WIDTH +: WIDTH] = head_q;

    // Buffer update: head always holds the oldest word, tail the next one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        occ_q  <= 2'd0;
        head_q <= '0;
        tail_q <= '0;
      end else begin
        case ({acc, psh})
          2'b11: begin
            // Head leaves; new word lands in whichever slot frees up
            if (occ_q == 2'd2) begin
              head_q <= tail_q;
              tail_q <= din;
            end else begin
              head_q <= din;
            end
          end
          2'b10: begin
            if (occ_q == 2'd0) head_q <= din;
            else               tail_q <= din;
            occ_q <= occ_q + 2'd1;
          end
          2'b01: begin
            head_q <= tail_q;
            occ_q  <= occ_q - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Magic FSM state, sampled index and lane-0 push counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && arm) begin
        idx_q <= magic_idx;
        cnt_q <= '0;
      end else if (state_q == COUNT && push[0]) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Next state and start tag; a push in the arming cycle is never counted
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE:  if (arm) state_d = COUNT;
      COUNT: begin
        if (push[0] && (cnt_q == idx_q)) begin
          start   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign armed = (state_q == COUNT);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_ingress_stager.sv
// Bench for ingress_stager with two lanes: scoreboard queues per lane track
// accepted words and are checked against every push; scenario tasks check
// timing, back-pressure, reset and the magic packet tag.
module tb_ingress_stager;

  localparam int WIDTH    = 8;
  localparam int NUM_REQS = 2;
  localparam int IDXWID   = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQS-1:0]       in_vld = '0;
  logic [NUM_REQS-1:0]       in_rdy;
  logic [NUM_REQS*WIDTH-1:0] flat_in_data;
  logic [NUM_REQS-1:0]       full = '0;
  logic [NUM_REQS-1:0]       push;
  logic [NUM_REQS*WIDTH-1:0] flat_data_out;
  logic                      arm = 1'b0;
  logic [IDXWID-1:0]         magic_idx = '0;
  logic                      start;
  logic                      armed;
  logic                      done;

  logic [WIDTH-1:0] din0 = '0;
  logic [WIDTH-1:0] din1 = '0;
  logic [WIDTH-1:0] dout0;
  logic [WIDTH-1:0] dout1;

  assign flat_in_data = {din1, din0};
  assign dout0 = flat_data_out[7:0];
  assign dout1 = flat_data_out[15:8];

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] sb0[$];
  logic [WIDTH-1:0] sb1[$];
  int start_cnt = 0;
  logic [WIDTH-1:0] start_data = '0;

  ingress_stager #(.WIDTH(WIDTH), .NUM_REQS(NUM_REQS), .IDXWID(IDXWID)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .flat_in_data(flat_in_data), .full(full), .push(push),
    .flat_data_out(flat_data_out), .arm(arm), .magic_idx(magic_idx),
    .start(start), .armed(armed), .done(done)
  );

  always #5 clk = ~clk;

  // Scoreboard: pop/compare on each push, enqueue each accept
  always @(negedge clk) begin
    if (rst) begin
      if (push[0]) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++;
          $display("FAIL sb_lane0 unexpected push data=%02h expected none", dout0);
        end else begin
          logic [WIDTH-1:0] e0;
          e0 = sb0.pop_front();
          if (dout0 !== e0) begin
            errors++;
            $display("FAIL sb_lane0 data=%02h expected=%02h", dout0, e0);
          end
        end
      end
      if (push[1]) begin
        checks++;
        if (sb1.size() == 0) begin
          errors++;
          $display("FAIL sb_lane1 unexpected push data=%02h expected none", dout1);
        end else begin
          logic [WIDTH-1:0] e1;
          e1 = sb1.pop_front();
          if (dout1 !== e1) begin
            errors++;
            $display("FAIL sb_lane1 data=%02h expected=%02h", dout1, e1);
          end
        end
      end
      if (start) begin
        checks++;
        if (push[0] !== 1'b1) begin
          errors++;
          $display("FAIL start_without_push push0=%b expected=1", push[0]);
        end
        start_cnt++;
        start_data = dout0;
      end
      if (in_vld[0] && in_rdy[0]) sb0.push_back(din0);
      if (in_vld[1] && in_rdy[1]) sb1.push_back(din1);
    end
  end

  task automatic clear_inputs();
    in_vld = '0; full = '0; arm = 1'b0; magic_idx = '0; din0 = '0; din1 = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b0;
    sb0.delete(); sb1.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    rst = 1'b0;
    in_vld = 2'($urandom); full = 2'($urandom); arm = 1'($urandom);
    magic_idx = 8'($urandom); din0 = 8'($urandom); din1 = 8'($urandom);
    #1;
    checks++;
    if (in_rdy !== 2'b11) begin errors++; $display("FAIL reset_in_rdy got=%b expected=11", in_rdy); end
    checks++;
    if (push !== 2'b00) begin errors++; $display("FAIL reset_push got=%b expected=00", push); end
    checks++;
    if (flat_data_out !== 16'h0) begin errors++; $display("FAIL reset_data got=%h expected=0000", flat_data_out); end
    checks++;
    if ({start, armed, done} !== 3'b000) begin
      errors++; $display("FAIL reset_fsm start/armed/done=%b expected=000", {start, armed, done});
    end
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      in_vld[0] = 1'b1; din0 = 8'(k);
      checks++;
      if (in_rdy[0] !== 1'b1) begin errors++; $display("FAIL stream_rdy k=%0d got=%b expected=1", k, in_rdy[0]); end
      @(negedge clk);
      checks++;
      if (push[0] !== (k > 1)) begin errors++; $display("FAIL stream_push k=%0d got=%b expected=%b", k, push[0], k > 1); end
      if (k > 1) begin
        checks++;
        if (dout0 !== 8'(k - 1)) begin errors++; $display("FAIL stream_data got=%02h expected=%02h", dout0, 8'(k - 1)); end
      end
    end
    @(posedge clk); #1;
    in_vld[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (push[0] !== 1'b1 || dout0 !== 8'h05) begin
      errors++; $display("FAIL stream_last push=%b data=%02h expected push=1 data=05", push[0], dout0);
    end
    @(posedge clk); #1;
    checks++;
    if (push[0] !== 1'b0) begin errors++; $display("FAIL stream_idle push=%b expected=0", push[0]); end
  endtask

  task automatic test_full();
    logic [7:0] offer [3];
    offer[0] = 8'h11; offer[1] = 8'h12; offer[2] = 8'h13;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      full[0] = 1'b1; in_vld[0] = 1'b1; din0 = offer[(k < 2) ? k : 2];
      checks++;
      if (in_rdy[0] !== (k < 2)) begin errors++; $display("FAIL full_rdy k=%0d got=%b expected=%b", k, in_rdy[0], k < 2); end
      checks++;
      if (push[0] !== 1'b0) begin errors++; $display("FAIL full_push k=%0d got=%b expected=0", k, push[0]); end
    end
    @(posedge clk); #1;
    full[0] = 1'b0;
    #1;
    checks++;
    if (push[0] !== 1'b1 || dout0 !== 8'h11 || in_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL full_release push=%b data=%02h rdy=%b expected 1/11/0", push[0], dout0, in_rdy[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (push[0] !== 1'b1 || dout0 !== 8'h12 || in_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL full_second push=%b data=%02h rdy=%b expected 1/12/1", push[0], dout0, in_rdy[0]);
    end
    @(posedge clk); #1;
    in_vld[0] = 1'b0;
    checks++;
    if (push[0] !== 1'b1 || dout0 !== 8'h13) begin
      errors++; $display("FAIL full_third push=%b data=%02h expected 1/13", push[0], dout0);
    end
    @(posedge clk); #1;
    checks++;
    if (push[0] !== 1'b0 || in_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL full_drained push=%b rdy=%b expected 0/1", push[0], in_rdy[0]);
    end
  endtask

  task automatic test_magic();
    int base;
    base = start_cnt;
    @(posedge clk); #1;
    arm = 1'b1; magic_idx = 8'd3; in_vld[0] = 1'b1; din0 = 8'hA0;
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL magic_pre_armed got=%b expected=0", armed); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      arm = 1'b0; din0 = 8'hA0 + 8'(k);
      if (k == 1) begin
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL magic_armed got=%b expected=1", armed); end
      end
    end
    @(posedge clk); #1;
    in_vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (start_cnt !== base + 1 || start_data !== 8'hA3) begin
      errors++; $display("FAIL magic_tag count=%0d data=%02h expected count=%0d data=A3", start_cnt - base, start_data, 1);
    end
    checks++;
    if (done !== 1'b1 || armed !== 1'b0) begin
      errors++; $display("FAIL magic_done done=%b armed=%b expected 1/0", done, armed);
    end
    @(posedge clk); #1;
    arm = 1'b1; magic_idx = 8'd0; in_vld[0] = 1'b1; din0 = 8'hB0;
    @(posedge clk); #1;
    arm = 1'b0; din0 = 8'hB1;
    @(posedge clk); #1;
    in_vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (start_cnt !== base + 1 || done !== 1'b1 || armed !== 1'b0) begin
      errors++; $display("FAIL magic_rearm starts=%0d done=%b armed=%b expected 1/1/0", start_cnt - base, done, armed);
    end
  endtask

  task automatic test_arm_same_cycle();
    int base;
    do_reset();
    base = start_cnt;
    @(posedge clk); #1;
    in_vld[0] = 1'b1; din0 = 8'h10;
    @(posedge clk); #1;
    arm = 1'b1; magic_idx = 8'd0; din0 = 8'h11;
    checks++;
    if (push[0] !== 1'b1 || dout0 !== 8'h10 || start !== 1'b0) begin
      errors++; $display("FAIL arm_cycle push=%b data=%02h start=%b expected 1/10/0", push[0], dout0, start);
    end
    @(posedge clk); #1;
    arm = 1'b0; in_vld[0] = 1'b0;
    checks++;
    if (start !== 1'b1 || push[0] !== 1'b1 || dout0 !== 8'h11) begin
      errors++; $display("FAIL arm_next start=%b push=%b data=%02h expected 1/1/11", start, push[0], dout0);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || start_cnt !== base + 1 || start_data !== 8'h11) begin
      errors++; $display("FAIL arm_done done=%b starts=%0d data=%02h expected 1/1/11", done, start_cnt - base, start_data);
    end
  endtask

  task automatic test_two_lanes_reset();
    int base;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      in_vld = {1'b1, (k < 2) ? 1'b1 : 1'b0};
      din0 = 8'hC0 + 8'(k);
      din1 = 8'($urandom);
      full = {k[0], 1'b1};
    end
    @(posedge clk); #3;
    checks++;
    if (in_rdy[0] !== 1'b0 || push[0] !== 1'b0) begin
      errors++; $display("FAIL lanes_occ2 rdy0=%b push0=%b expected 0/0", in_rdy[0], push[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 2'b11 || push !== 2'b00 || flat_data_out !== 16'h0) begin
      errors++; $display("FAIL async_reset rdy=%b push=%b data=%h expected 11/00/0000", in_rdy, push, flat_data_out);
    end
    sb0.delete(); sb1.delete();
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    base = start_cnt;
    @(posedge clk); #1;
    arm = 1'b1; magic_idx = 8'd0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      arm = 1'b0; in_vld[1] = 1'b1; din1 = 8'hD0 + 8'(k);
    end
    @(posedge clk); #1;
    in_vld[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (start_cnt !== base || armed !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL lane1_no_start starts=%0d armed=%b done=%b expected 0/1/0", start_cnt - base, armed, done);
    end
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++; $display("FAIL sb_leftover lane0=%0d lane1=%0d expected 0/0", sb0.size(), sb1.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_magic();
    test_arm_same_cycle();
    test_two_lanes_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ingress_stager.md
# ingress_stager

Per-requestor ingress staging stage in front of the data-integrity scoreboard's FIFOs. Accepts a valid/ready stream on each lane and holds it in a 2-entry skid buffer. Converts it into `push`/data that never violates the FIFO `full` flag. On lane 0, it generates the one-shot `start` tag that marks the Nth pushed packet as the magic packet.

## Interface

Parameters:
- `WIDTH`, 8, data width per lane
- `NUM_REQS`, 1, number of lanes (one per FIFO/requestor)
- `IDXWID`, 8, width of magic packet index and lane-0 push counter

Ports:
- `clk`  input  1  single clock; all state on rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `in_vld`  input  NUM_REQS  upstream word valid per lane
- `in_rdy`  output  NUM_REQS  stage can accept a word on lane
- `flat_in_data`  input  NUM_REQS*WIDTH  lane i at bits [(i+1)*WIDTH-1:i*WIDTH]
- `full`  input  NUM_REQS  FIFO full flags (combinational use allowed)
- `push`  output  NUM_REQS  FIFO push per lane
- `flat_data_out`  output  NUM_REQS*WIDTH  FIFO data_in per lane, same packing
- `arm`  input  1  request magic packet selection (pulse or level)
- `magic_idx`  input  IDXWID  0-based lane-0 push index to tag, sampled when arm is accepted
- `start`  output  1  high in the same cycle as `push[0]` of the tagged packet
- `armed`  output  1  FSM in COUNT
- `done`  output  1  tag issued; sticky until reset

## Operation

- Per lane: 2-entry in-order buffer (head, tail), occupancy `occ` in 0..2.
- `in_rdy[i] = (occ_q[i] != 2)`. This is a registered view with no combinational path from `full` or `in_vld`.
- Accept on lane i when `in_vld[i] & in_rdy[i]`. The word is written to head if the buffer is empty or becomes empty this cycle, otherwise to tail.
- `push[i] = (occ_q[i] != 0) & ~full[i]`. `flat_data_out` lane i = head.
- Accept and push in the same cycle: occ is unchanged, tail shifts to head, and the new word takes the freed slot. Order is always preserved.
- Accept only: occ+1. Push only: occ-1 and tail shifts to head.
- `full` held high: head/tail hold, push stays 0. No words are dropped and none are duplicated.
- Magic FSM (lane 0 only), 3 states:
  - IDLE: `arm` → COUNT, `idx_q <= magic_idx`, `cnt <= 0`.
  - COUNT: each `push[0]` increments `cnt` (IDXWID bits). `start = push[0] & (cnt == idx_q)`. When `start` is high → DONE.
  - DONE: absorbing. `arm` is ignored.
- A `push[0]` in the cycle `arm` is accepted is not counted. Counting begins the following cycle.
- `arm` while in COUNT or DONE is ignored. `magic_idx` is not re-sampled.
- `cnt` cannot wrap before a match, because the match fires at `cnt == idx_q`, which is at most 2^IDXWID-1.
- `start` is asserted only when `push[0]` is asserted, so the downstream capture (`start & push[0]`) sees exactly one packet.
- Lanes other than 0 never influence `start`.

## Timing

- Reset (`rst` low, asynchronous, no clock edge required):
  - occ=0, head/tail=0
  - `in_rdy`=all 1s, `push`=0, `flat_data_out`=0
  - FSM=IDLE, `start`=0, `armed`=0, `done`=0
- Latency: a word accepted at edge t is on `flat_data_out` with `push` high from cycle t+1 if `full` is low.
- Throughput: 1 word/cycle/lane steady state (occ stays at 1).
- `in_rdy` falls the cycle after occ reaches 2. It rises the cycle after a push at occ=2.
- `armed` rises the cycle after `arm` in IDLE. `done` rises the cycle after `start`.
- Reset asserted mid-operation: buffered words are discarded and the FSM returns to IDLE. The FIFO may retain words already pushed; a consistent reset of the FIFO is the system's responsibility.
- Deassertion of `rst` is synchronized by the system. The first accept is possible on the first edge after release.

## Test plan

1. Hold `rst` low with random inputs, no clock edges → `in_rdy`=1, `push`=0, `start`=0, `armed`=0, `done`=0 immediately.
2. Lane 0, `full`=0, `in_vld` for 5 cycles with data 0x01..0x05 → `push` high for 5 consecutive cycles starting 1 cycle after the first accept, data 0x01..0x05 in order, `in_rdy` constantly 1.
3. `full[0]`=1 for 6 cycles, then offer 0x11,0x12,0x13 → 0x11 and 0x12 accepted and `in_rdy` low from the cycle after the 2nd accept, `push`=0. Drop `full` → 0x11 then 0x12 pushed, `in_rdy`=1 after the first push, then 0x13 accepted.
4. `arm` with `magic_idx`=3, stream 0xA0..0xA5 → `start` high only with the push of 0xA3, `done`=1 afterwards. A second `arm` with `magic_idx`=0 → no further `start`.
5. `arm` with `magic_idx`=0 in the same cycle as the push of 0x10, then 0x11 → `start` coincides with 0x11, not 0x10.
6. NUM_REQS=2: lane 1 streams with `full[1]` toggling, lane 0 at occ=2, then async `rst` low between edges → both lanes clear at once, no `push`. After release, lane 1 activity never asserts `start`.
